// File: rtl/mmio_io_responder_if.sv
// Processor data-bus view of the MMIO I/O responder: address, store/load strobes and load return.
// The processor side is the master; the responder is the slave.
interface mmio_io_responder_if;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] ReadData;
    logic        Hit;

    modport master (
        output Address,
        output WriteData,
        output MemWrite,
        output MemRead,
        input  ReadData,
        input  Hit
    );

    modport slave (
        input  Address,
        input  WriteData,
        input  MemWrite,
        input  MemRead,
        output ReadData,
        output Hit
    );
endinterface

// File: rtl/mmio_io_responder.sv
// 64-byte MMIO window with an output port, a synchronised input port with rising-edge status,
// and a free-running compare timer; zero-wait-state single-cycle access for a simple CPU datapath.
module mmio_io_responder #(
    parameter logic [31:0] IO_BASE = 32'h1001_0000
) (
    input  logic                 clk,
    input  logic                 reset,
    mmio_io_responder_if.slave   bus,
    input  logic [7:0]           PortIn,
    output logic [31:0]          PortOut,
    output logic                 Irq
);
    localparam int DATA_W = 32;

    localparam logic [3:0] OFF_PORT_OUT  = 4'h0;
    localparam logic [3:0] OFF_PORT_IN   = 4'h1;
    localparam logic [3:0] OFF_EDGE_STAT = 4'h2;
    localparam logic [3:0] OFF_TCOUNT    = 4'h3;
    localparam logic [3:0] OFF_TCMP      = 4'h4;
    localparam logic [3:0] OFF_TCTRL     = 4'h5;
    localparam logic [3:0] OFF_TSTAT     = 4'h6;

    // Sticky status update: a new set always beats a same-cycle write-1-to-clear.
    function automatic logic [7:0] w1c_update(input logic [7:0] cur,
                                              input logic [7:0] clr,
                                              input logic [7:0] set);
        return (cur & ~clr) | set;
    endfunction

    logic [DATA_W-1:0] port_out;
    logic [7:0]        sync1;
    logic [7:0]        sync2;
    logic [7:0]        prev;
    logic [7:0]        edge_stat;
    logic [DATA_W-1:0] tcount;
    logic [DATA_W-1:0] tcmp;
    logic              tctrl_en;
    logic              tstat_match;

    logic [3:0]        offset;
    logic              hit;
    logic              wr;
    logic              rd;
    logic [7:0]        edge_rise;
    logic [7:0]        edge_clr;
    logic [7:0]        edge_next;
    logic              tmatch;
    logic              tstat_clr;
    logic              tstat_next;
    logic [DATA_W-1:0] tcount_next;
    logic [DATA_W-1:0] read_mux;

    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^bus.Address[1:0];

    // Address decode and strobes
    assign offset = bus.Address[5:2];
    assign hit    = (bus.Address[31:6] == IO_BASE[31:6]);
    assign wr     = bus.MemWrite && hit;
    assign rd     = bus.MemRead && hit;

    // Edge detector and timer next-state
    always_comb begin
        edge_rise   = sync2 & ~prev;
        edge_clr    = (wr && offset == OFF_EDGE_STAT) ? bus.WriteData[7:0] : 8'h00;
        edge_next   = w1c_update(edge_stat, edge_clr, edge_rise);

        // Match is judged on the pre-write count so a software reload cannot hide it.
        tmatch      = tctrl_en && (tcount == tcmp);
        tstat_clr   = wr && (offset == OFF_TSTAT) && bus.WriteData[0];
        tstat_next  = (tstat_match && !tstat_clr) || tmatch;

        tcount_next = tcount;
        if (wr && offset == OFF_TCOUNT)
            tcount_next = bus.WriteData;
        else if (tmatch)
            tcount_next = '0;
        else if (tctrl_en)
            tcount_next = tcount + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            port_out    <= '0;
            sync1       <= '0;
            sync2       <= '0;
            prev        <= '0;
            edge_stat   <= '0;
            tcount      <= '0;
            tcmp        <= '0;
            tctrl_en    <= 1'b0;
            tstat_match <= 1'b0;
        end else begin
            sync1       <= PortIn;
            sync2       <= sync1;
            prev        <= sync2;
            edge_stat   <= edge_next;
            tcount      <= tcount_next;
            tstat_match <= tstat_next;
            if (wr && offset == OFF_PORT_OUT) port_out <= bus.WriteData;
            if (wr && offset == OFF_TCMP)     tcmp     <= bus.WriteData;
            if (wr && offset == OFF_TCTRL)    tctrl_en <= bus.WriteData[0];
        end
    end

    // Load return path
    always_comb begin
        read_mux = '0;
        case (offset)
            OFF_PORT_OUT:  read_mux = port_out;
            OFF_PORT_IN:   read_mux = {24'h0, sync2};
            OFF_EDGE_STAT: read_mux = {24'h0, edge_stat};
            OFF_TCOUNT:    read_mux = tcount;
            OFF_TCMP:      read_mux = tcmp;
            OFF_TCTRL:     read_mux = {31'h0, tctrl_en};
            OFF_TSTAT:     read_mux = {31'h0, tstat_match};
            default:       read_mux = '0;
        endcase
    end

    assign bus.ReadData = rd ? read_mux : '0;
    assign bus.Hit      = hit;
    assign PortOut      = port_out;
    assign Irq          = (|edge_stat) || tstat_match;

endmodule

// File: doc/mmio_io_responder.md
MMIO_IO_RESPONDER -- requirements
Module: mmio_io_responder

Interface
REQ-001 SHALL have parameter IO_BASE, default 32'h1001_0000, giving the byte base of a 64-byte I/O window (decode on Address[31:6] == IO_BASE[31:6]).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates occur on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port Address, input, 32, byte address from the processor data bus; bits [1:0] are ignored.
REQ-005 SHALL have port WriteData, input, 32, store data from the processor.
REQ-006 SHALL have port MemWrite, input, 1, store strobe, sampled on each clk rising edge.
REQ-007 SHALL have port MemRead, input, 1, load strobe.
REQ-008 SHALL have port PortIn, input, 8, asynchronous external input pins.
REQ-009 SHALL have port ReadData, output, 32, combinational load data.
REQ-010 SHALL have port Hit, output, 1, combinational; high when Address falls in the window.
REQ-011 SHALL have port PortOut, output, 32, the PORT_OUT register value.
REQ-012 SHALL have port Irq, output, 1, combinational OR of all EDGE_STAT bits and TSTAT.match.

Function
REQ-013 SHALL implement word registers at these offsets: 0x00 PORT_OUT (RW); 0x04 PORT_IN (RO, {24'b0,sync2}); 0x08 EDGE_STAT[7:0] (RO, write-1-to-clear); 0x0C TCOUNT (RW); 0x10 TCMP (RW); 0x14 TCTRL[0] enable (RW); 0x18 TSTAT[0] match (RO, write-1-to-clear).
REQ-014 SHALL drive ReadData with the addressed register, zero-extended, in the same cycle when MemRead && Hit; otherwise ReadData = 0. Unmapped offsets 0x1C-0x3C SHALL read 0.
REQ-015 SHALL perform a register write at the clk rising edge when MemWrite && Hit; writes to RO or unmapped offsets SHALL be ignored; a write when Hit = 0 SHALL change nothing.
REQ-016 SHALL synchronize PortIn through two flops (sync1, sync2) and keep a delayed copy prev <= sync2.
  - A PortIn change set up before edge N SHALL appear on sync2 after edge N+1.
REQ-017 SHALL set EDGE_STAT[i] on the edge after (sync2[i] && !prev[i]), i.e. edge N+2.
  - Falling edges SHALL NOT set status.
REQ-018 SHALL give set priority over a same-cycle W1C clear of the same EDGE_STAT bit.
REQ-019 SHALL increment TCOUNT by 1 each cycle while TCTRL.enable = 1, wrapping 0xFFFF_FFFF -> 0.
REQ-020 SHALL, when enable = 1 and TCOUNT == TCMP:
  - load TCOUNT with 0 on the next edge instead of incrementing;
  - set TSTAT.match on that same edge.
REQ-021 SHALL evaluate match on the pre-write TCOUNT value; a same-cycle TCOUNT write SHALL win over increment or auto-reload, while match still sets.
REQ-022 SHALL give match-set priority over a same-cycle W1C of TSTAT.match.
REQ-023 SHALL freeze TCOUNT while enable = 0, and generate no match in that state.
REQ-024 SHALL require no wait states: every access completes in one cycle, consistent with a single-cycle datapath.

Reset
REQ-025 SHALL, while reset = 0, asynchronously clear all of the following to 0: PORT_OUT, sync1, sync2, prev, EDGE_STAT, TCOUNT, TCMP, TCTRL, TSTAT.
  - Hence PortOut = 0, Irq = 0, and ReadData = 0 unless a read is active.
REQ-026 SHALL abandon any in-progress count, pending edge or write when reset is asserted mid-operation; nothing SHALL be retained.
REQ-027 SHALL resume normal operation on the first clk rising edge after reset deasserts.

Verification
REQ-028 SHALL be verified by this sequence: store 0xA5A5_0F0F to 0x1001_0000 -> PortOut = 0xA5A5_0F0F after that edge; a load from 0x1001_0000 then returns 0xA5A5_0F0F; a store to 0x1001_0100 leaves PortOut unchanged and Hit = 0.
REQ-029 SHALL be verified by this sequence: PortIn 0x00 -> 0x81 before edge N:
  - a PORT_IN load returns 0x81 from after edge N+1;
  - EDGE_STAT = 0x81 and Irq = 1 after edge N+2;
  - storing 0x01 to 0x08 leaves EDGE_STAT = 0x80.
REQ-030 SHALL be verified by this sequence: TCMP = 3, TCOUNT = 0, enable = 1 -> TCOUNT sequence 1, 2, 3, 0, 1, with TSTAT.match = 1 from the edge where TCOUNT returns to 0.
REQ-031 SHALL be verified by this sequence: W1C to TSTAT in the same cycle a match occurs -> TSTAT.match remains 1; W1C of EDGE_STAT bit 2 in the same cycle bit 2 rises -> bit remains 1.
REQ-032 SHALL be verified by this sequence: TCOUNT = 0xFFFF_FFFF, TCMP = 5, enable = 1 -> TCOUNT = 0 next edge, no match.
REQ-033 SHALL be verified by this sequence: assert reset with TCOUNT = 7 and EDGE_STAT = 0x10 between clock edges -> all registers and PortOut read 0 immediately, without waiting for clk.
